// File: rtl/ddc_pkg.sv
// Shared types and helpers for the down-conversion sequencing controller.
package ddc_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StFill  = 2'd1,
      StRun   = 2'd2,
      StFlush = 2'd3
   } ddc_state_e;

   localparam logic [1:0] STATE_IDLE  = 2'd0;
   localparam logic [1:0] STATE_FILL  = 2'd1;
   localparam logic [1:0] STATE_RUN   = 2'd2;
   localparam logic [1:0] STATE_FLUSH = 2'd3;

   // Counter width able to hold values 0..n-1, never narrower than one bit.
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ddc_out_hold.sv
// One-entry output register with valid/ready handshake and a saturating
// count of captures dropped while the held word was still unconsumed.
module ddc_out_hold #(
   parameter int unsigned OUT_W = 66,
   parameter int unsigned CNT_W = 16
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   input  logic             cap_i,
   input  logic [OUT_W-1:0] data_i,
   input  logic             ready_i,
   output logic [OUT_W-1:0] data_o,
   output logic             valid_o,
   output logic [CNT_W-1:0] ovf_cnt_o
);

   logic [OUT_W-1:0] data_q, data_d;
   logic             valid_q, valid_d;
   logic [CNT_W-1:0] ovf_q, ovf_d;
   logic             hs;

   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      ovf_d   = ovf_q;
      hs      = valid_q & ready_i;
      if (cap_i) begin
         if (!valid_q || hs) begin
            data_d  = data_i;
            valid_d = 1'b1;
         end else if (ovf_q != {CNT_W{1'b1}}) begin
            ovf_d = ovf_q + 1'b1;
         end
      end else if (hs) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         data_q  <= '0;
         valid_q <= 1'b0;
         ovf_q   <= '0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
         ovf_q   <= ovf_d;
      end
   end

   assign data_o    = data_q;
   assign valid_o   = valid_q;
   assign ovf_cnt_o = ovf_q;

endmodule

// File: rtl/ddc_sched.sv
// Sequencer for the mixer/decimating-FIR datapath: primes the filter,
// decimates its output and drains the held word cleanly on stop.
module ddc_sched
   import ddc_pkg::*;
#(
   parameter int unsigned DECIM    = 8,
   parameter int unsigned FILT_LAT = 12,
   parameter int unsigned OUT_W    = 66,
   parameter int unsigned CNT_W    = 16
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   input  logic             run,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             dp_ce,
   input  logic [OUT_W-1:0] filt_data,
   output logic [OUT_W-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy,
   output logic [CNT_W-1:0] overflow_cnt,
   output logic [1:0]       state
);

   localparam int unsigned PhW   = cnt_w(DECIM);
   localparam int unsigned FillW = cnt_w(FILT_LAT + 1);
   localparam logic [PhW-1:0]   PhLast   = PhW'(DECIM - 1);
   localparam logic [FillW-1:0] FillLast = FillW'(FILT_LAT - 1);

   ddc_state_e       state_q, state_d;
   logic [PhW-1:0]   phase_q, phase_d;
   logic [FillW-1:0] fill_q, fill_d;
   logic             in_ready_q, in_ready_d;
   logic             cap_q, cap_d;

   assign dp_ce = in_valid & in_ready_q;

   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      fill_d  = fill_q;
      cap_d   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (run) begin
               state_d = StFill;
               phase_d = '0;
               fill_d  = '0;
            end
         end
         StFill: begin
            if (!run) begin
               state_d = StIdle;
            end else if (dp_ce) begin
               fill_d = fill_q + 1'b1;
               if (fill_q == FillLast) begin
                  state_d = StRun;
                  phase_d = '0;
               end
            end
         end
         StRun: begin
            // Once run drops no new capture is scheduled; a pending one still lands.
            if (!run) begin
               state_d = StFlush;
            end else if (dp_ce) begin
               phase_d = (phase_q == PhLast) ? '0 : phase_q + 1'b1;
               cap_d   = (phase_q == PhLast);
            end
         end
         StFlush: begin
            if (!out_valid && !cap_q) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
      in_ready_d = (state_d == StFill) || (state_d == StRun);
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q    <= StIdle;
         phase_q    <= '0;
         fill_q     <= '0;
         in_ready_q <= 1'b0;
         cap_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         phase_q    <= phase_d;
         fill_q     <= fill_d;
         in_ready_q <= in_ready_d;
         cap_q      <= cap_d;
      end
   end

   ddc_out_hold #(
      .OUT_W(OUT_W),
      .CNT_W(CNT_W)
   ) u_out_hold (
      .sys_clk  (sys_clk),
      .sys_rst  (sys_rst),
      .cap_i    (cap_q),
      .data_i   (filt_data),
      .ready_i  (out_ready),
      .data_o   (out_data),
      .valid_o  (out_valid),
      .ovf_cnt_o(overflow_cnt)
   );

   assign in_ready = in_ready_q;
   assign busy     = (state_q != StIdle);
   assign state    = state_q;

endmodule

// File: tb/tb_ddc_sched.sv
// Bench for ddc_sched: directed scenarios plus random traffic, all checked
// cycle by cycle against a step-counting reference model.
module tb_ddc_sched;

   localparam int unsigned DECIM    = 4;
   localparam int unsigned FILT_LAT = 3;
   localparam int unsigned OUT_W    = 66;
   localparam int unsigned CNT_W    = 4;
   localparam int          OVF_MAX  = (1 << CNT_W) - 1;

   logic             sys_clk = 1'b0;
   logic             sys_rst, run, in_valid, out_ready;
   logic             in_ready, dp_ce, out_valid, busy;
   logic [OUT_W-1:0] filt_data = '0;
   logic [OUT_W-1:0] out_data;
   logic [CNT_W-1:0] overflow_cnt;
   logic [1:0]       state;

   ddc_sched #(
      .DECIM   (DECIM),
      .FILT_LAT(FILT_LAT),
      .OUT_W   (OUT_W),
      .CNT_W   (CNT_W)
   ) dut (
      .sys_clk     (sys_clk),
      .sys_rst     (sys_rst),
      .run         (run),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .dp_ce       (dp_ce),
      .filt_data   (filt_data),
      .out_data    (out_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .busy        (busy),
      .overflow_cnt(overflow_cnt),
      .state       (state)
   );

   always #5 sys_clk = ~sys_clk;

   // Filter stand-in: after each datapath step the output carries the step index.
   logic [31:0] step_cnt = '0;
   always @(posedge sys_clk) begin
      if (sys_rst) begin
         step_cnt <= '0;
      end else if (dp_ce) begin
         filt_data <= {32'($urandom), 2'($urandom), step_cnt};
         step_cnt  <= step_cnt + 1;
      end
   end

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // Reference model in terms of states, step counts and a one-word buffer.
   int               m_state = 0;
   int               m_steps = 0;
   bit               m_pend  = 0;
   bit               m_valid = 0;
   logic [OUT_W-1:0] m_data  = '0;
   int               m_ovf   = 0;

   bit               rec = 0;
   int               w_cyc[$];
   logic [OUT_W-1:0] w_dat[$];

   task automatic chk(input string tag, input logic [OUT_W-1:0] obs,
                      input logic [OUT_W-1:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cycle();
      logic             s_rst, s_run, s_or, e_ce, o_valid, o_pend;
      logic [OUT_W-1:0] s_filt;
      #1;
      e_ce = in_valid && (m_state == 1 || m_state == 2);
      chk("dp_ce", OUT_W'(dp_ce), OUT_W'(e_ce));
      s_rst  = sys_rst;
      s_run  = run;
      s_or   = out_ready;
      s_filt = filt_data;
      @(posedge sys_clk);
      cyc++;
      if (s_rst) begin
         m_state = 0; m_steps = 0; m_pend = 0; m_valid = 0; m_data = '0; m_ovf = 0;
      end else begin
         o_valid = m_valid;
         o_pend  = m_pend;
         if (o_pend) begin
            if (!o_valid || s_or) begin
               m_data  = s_filt;
               m_valid = 1;
            end else if (m_ovf < OVF_MAX) begin
               m_ovf++;
            end
         end else if (o_valid && s_or) begin
            m_valid = 0;
         end
         m_pend = 0;
         case (m_state)
            0: if (s_run) begin m_state = 1; m_steps = 0; end
            1: if (!s_run) m_state = 0;
               else if (e_ce) begin
                  m_steps++;
                  if (m_steps == FILT_LAT) m_state = 2;
               end
            2: if (!s_run) m_state = 3;
               else if (e_ce) begin
                  m_steps++;
                  if ((m_steps - FILT_LAT) % DECIM == 0) m_pend = 1;
               end
            default: if (!o_valid && !o_pend) m_state = 0;
         endcase
      end
      #1;
      chk("state", OUT_W'(state), OUT_W'(m_state));
      chk("busy", OUT_W'(busy), OUT_W'(m_state != 0));
      chk("in_ready", OUT_W'(in_ready), OUT_W'(m_state == 1 || m_state == 2));
      chk("out_valid", OUT_W'(out_valid), OUT_W'(m_valid));
      chk("overflow_cnt", OUT_W'(overflow_cnt), OUT_W'(m_ovf));
      if (m_valid) chk("out_data", out_data, m_data);
      if (rec && out_valid === 1'b1) begin
         w_cyc.push_back(cyc);
         w_dat.push_back(out_data);
      end
   endtask

   initial begin
      logic [OUT_W-1:0] held;
      bit               have;
      int               k;

      sys_rst = 1; run = 0; in_valid = 0; out_ready = 0;
      cycle();
      cycle();
      chk("rst_out_data", out_data, '0);
      chk("rst_state", OUT_W'(state), '0);
      chk("rst_ovf", OUT_W'(overflow_cnt), '0);

      // Primed decimation.
      sys_rst = 0; run = 1; in_valid = 1; out_ready = 1; rec = 1;
      for (int i = 0; i < 30; i++) cycle();
      rec = 0;
      chk("prime_words", OUT_W'(w_dat.size() >= 4), OUT_W'(1));
      if (w_dat.size() >= 4) begin
         chk("prime_first", OUT_W'(w_dat[0][31:0]), OUT_W'(6));
         chk("prime_second", OUT_W'(w_dat[1][31:0]), OUT_W'(10));
         chk("prime_third", OUT_W'(w_dat[2][31:0]), OUT_W'(14));
         chk("prime_gap", OUT_W'(w_cyc[1] - w_cyc[0]), OUT_W'(DECIM));
         chk("prime_gap2", OUT_W'(w_cyc[3] - w_cyc[2]), OUT_W'(DECIM));
      end

      // Stall overflow: align to a just-consumed word, then stall 12 steps.
      k = 0;
      while (!m_valid && k < 20) begin cycle(); k++; end
      cycle();
      out_ready = 0;
      have = 0;
      held = '0;
      for (int i = 0; i < 12; i++) begin
         cycle();
         if (out_valid === 1'b1) begin
            if (!have) begin held = out_data; have = 1; end
            else chk("stall_hold", out_data, held);
         end
      end
      chk("stall_valid", OUT_W'(out_valid), OUT_W'(1));
      chk("stall_ovf", OUT_W'(overflow_cnt), OUT_W'(2));

      // Handshake on the capture edge.
      k = 0;
      while (!m_pend && k < 20) begin cycle(); k++; end
      chk("hs_cap_found", OUT_W'(m_pend), OUT_W'(1));
      out_ready = 1;
      cycle();
      chk("hs_cap_valid", OUT_W'(out_valid), OUT_W'(1));
      chk("hs_cap_ovf", OUT_W'(overflow_cnt), OUT_W'(2));
      chk("hs_cap_word", OUT_W'(out_data[31:0]), OUT_W'(held[31:0] + 12));

      // Stop with a capture pending, then drain.
      out_ready = 0;
      k = 0;
      while (!(m_pend && !m_valid) && k < 20) begin out_ready = 1; cycle(); k++; end
      run = 0; out_ready = 0;
      cycle();
      chk("flush_state", OUT_W'(state), OUT_W'(3));
      chk("flush_in_ready", OUT_W'(in_ready), OUT_W'(0));
      chk("flush_dp_ce", OUT_W'(dp_ce), OUT_W'(0));
      chk("flush_valid", OUT_W'(out_valid), OUT_W'(1));
      held = out_data;
      for (int i = 0; i < 4; i++) begin
         cycle();
         chk("flush_hold", out_data, held);
         chk("flush_stay", OUT_W'(state), OUT_W'(3));
      end
      out_ready = 1;
      cycle();
      chk("flush_after_hs", OUT_W'(state), OUT_W'(3));
      out_ready = 0;
      cycle();
      chk("flush_idle", OUT_W'(state), OUT_W'(0));

      // Restart keeps the drop count; reset mid-RUN with a held word.
      run = 1; in_valid = 1; out_ready = 0;
      cycle();
      chk("restart_ovf_kept", OUT_W'(overflow_cnt), OUT_W'(2));
      k = 0;
      while (m_ovf != 5 && k < 100) begin cycle(); k++; end
      chk("pre_rst_ovf", OUT_W'(overflow_cnt), OUT_W'(5));
      chk("pre_rst_valid", OUT_W'(out_valid), OUT_W'(1));
      sys_rst = 1;
      cycle();
      chk("midrst_state", OUT_W'(state), '0);
      chk("midrst_valid", OUT_W'(out_valid), '0);
      chk("midrst_data", out_data, '0);
      chk("midrst_ovf", OUT_W'(overflow_cnt), '0);
      chk("midrst_ready", OUT_W'({in_ready, dp_ce, busy}), '0);
      sys_rst = 0; run = 0; in_valid = 0;
      cycle();

      // Gapped input: one step every other cycle.
      run = 1; out_ready = 1; rec = 1;
      w_cyc.delete();
      w_dat.delete();
      for (int i = 0; i < 60; i++) begin
         in_valid = (i % 2 == 0);
         cycle();
      end
      rec = 0;
      chk("gap_words", OUT_W'(w_cyc.size() >= 4), OUT_W'(1));
      if (w_cyc.size() >= 4) begin
         for (int i = 1; i < 4; i++)
            chk("gap_spacing", OUT_W'(w_cyc[i] - w_cyc[i-1]), OUT_W'(2 * DECIM));
      end

      // Random traffic: heavy stalls first, then mostly ready.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 39) == 0) run = ~run;
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = (i < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         sys_rst   = ($urandom_range(0, 499) == 0);
         cycle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ddc_sched.md
Name: ddc_sched

Overview:
- Sequencing controller for the FM down-conversion datapath (mixer feeding the decimating FIR).
- Accepts the input sample stream and drives the datapath clock-enable.
- Suppresses filter outputs until the FIR pipeline is primed, then decimates the filter output by DECIM.
- Presents decimated words on a valid/ready port, counts samples dropped by downstream stalls, and handles start/stop with a clean drain.

Parameters:
- DECIM, 8, decimation ratio; integer 2..256.
- FILT_LAT, 12, accepted samples discarded after start while the FIR fills; integer 1..1023.
- OUT_W, 66, filter output word width in bits.
- CNT_W, 16, overflow counter width in bits.

Ports:
- sys_clk  in  1  clock for all logic.
- sys_rst  in  1  synchronous, active-high reset.
- run  in  1  level; 1 = stream enabled.
- in_valid  in  1  upstream sample present this cycle.
- in_ready  out  1  controller accepts the upstream sample.
- dp_ce  out  1  clock-enable to mixer and filter; one datapath step per high cycle.
- filt_data  in  OUT_W  filter output, signed; valid the cycle after a dp_ce step.
- out_data  out  OUT_W  decimated output word, signed.
- out_valid  out  1  out_data holds an unconsumed word.
- out_ready  in  1  downstream accepts out_data.
- busy  out  1  state != IDLE.
- overflow_cnt  out  CNT_W  saturating count of decimated words dropped.
- state  out  2  IDLE=0, FILL=1, RUN=2, FLUSH=3.

Behaviour:
- Reset: every output is 0. State is IDLE. Phase, fill and overflow counters clear. A reset asserted mid-stream discards the held word with no drain.
- dp_ce = in_valid & in_ready; purely combinational from registered in_ready.
- IDLE: in_ready=0. run=1 moves to FILL and clears the phase and fill counters. overflow_cnt is kept; it clears only on reset.
- FILL:
  - in_ready=1; each dp_ce increments the fill counter.
  - When the FILT_LAT-th step occurs, the state moves to RUN on the next edge with phase=0. No output is produced in FILL.
  - run=0 in FILL moves directly to IDLE.
- RUN:
  - in_ready=1; upstream is never back-pressured (real-time stream).
  - The phase counter increments on each dp_ce and wraps DECIM-1 -> 0.
  - A dp_ce at cycle t with phase==DECIM-1 marks a capture at t+1: filt_data is sampled at that edge. out_valid=1 and out_data are visible from cycle t+2.
- Output register (one entry):
  - Handshake completes when out_valid & out_ready on a rising edge; out_valid then drops unless a capture lands on the same edge.
  - Capture with out_valid=0, or capture on the same edge as a handshake: load the new word, out_valid=1, no overflow.
  - Capture with out_valid=1 and out_ready=0: keep the old word and increment overflow_cnt, saturating at all-ones.
  - out_data is stable while out_valid=1 and out_ready=0.
- run=0 in RUN moves to FLUSH.
  - A capture already pending from the previous cycle's dp_ce still completes.
  - The phase counter is not advanced further.
- FLUSH: in_ready=0, dp_ce=0. When out_valid=0 and no capture is pending, move to IDLE. run=1 in FLUSH has no effect until IDLE is reached; restart then goes through FILL again.
- Widths: no arithmetic on data; the word passes through bit-exact, signed OUT_W.

Decomposition:
- Package ddc_pkg: state encoding (IDLE/FILL/RUN/FLUSH as a 2-bit typedef), state constants, and a helper giving the counter widths clog2(DECIM) and clog2(FILT_LAT+1).
- Sub-module ddc_out_hold: the one-entry output register with valid/ready and the saturating overflow counter. The FSM, fill counter and phase counter live in ddc_sched.

Test Plan:
- Directed test, primed decimation:
  - Setup: DECIM=4, FILT_LAT=3, in_valid=1 continuously, out_ready=1, filt_data = step index.
  - Required: no out_valid during the first 3 steps. The first word equals the step-6 value (filter output of the 4th RUN step), then one word every 4 cycles.
- Directed test, stall overflow:
  - Setup: out_ready=0 for 12 steps in RUN with DECIM=4.
  - Required: out_valid stays 1 on the first captured word; overflow_cnt=2; out_data is unchanged throughout.
- Directed test, simultaneous handshake and capture:
  - Setup: out_ready=1 on exactly the capture edge while out_valid=1.
  - Required: the new word loads, out_valid remains 1, overflow_cnt unchanged.
- Directed test, stop and drain:
  - Setup: drop run one cycle after a phase==DECIM-1 dp_ce, holding out_ready=0 for 5 cycles.
  - Required: state FLUSH, dp_ce=0, in_ready=0. The word appears and holds, then state=IDLE one edge after the handshake.
- Directed test, reset mid-RUN with out_valid=1 and overflow_cnt=5:
  - Required: next cycle all outputs 0, state=IDLE.
- Directed test, gapped input:
  - Setup: in_valid toggling 1,0,1,0.
  - Required: the phase advances only on dp_ce; decimated words are spaced 2*DECIM cycles apart.
